// File: rtl/digit_scan_driver.sv
//------------------------------------------------------------------------------
// digit_scan_driver : double-buffered 7-digit hex frame, 7-seg decode, dead-time blanked scan
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module digit_scan_driver #(
   parameter int NUM_DIGITS   = 7,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [2:0]              digit_sel,
   input  logic                    wr_en,
   input  logic [4*NUM_DIGITS-1:0] wr_data,
   input  logic [NUM_DIGITS-1:0]   wr_dp,
   output logic [NUM_DIGITS-1:0]   anode_n,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic                    frame_start,
   output logic                    sel_err
);

   localparam logic [3:0] c_BLANK = 4'(BLANK_CYCLES);
   localparam logic [3:0] c_NUM   = 4'(NUM_DIGITS);
   localparam logic [2:0] c_LAST  = 3'(NUM_DIGITS - 1);

   logic [4*NUM_DIGITS-1:0] r_stage_data, r_act_data;
   logic [NUM_DIGITS-1:0]   r_stage_dp, r_act_dp;
   logic [2:0]              r_prev_sel;
   logic [3:0]              r_blank_cnt;

   logic [4*NUM_DIGITS-1:0] w_act_data_nxt;
   logic [NUM_DIGITS-1:0]   w_act_dp_nxt;
   logic [NUM_DIGITS-1:0]   w_anode;
   logic [NUM_DIGITS-1:0]   w_lz_mask;
   logic [3:0]              w_nib;
   logic [6:0]              w_seg;
   logic                    w_dp_bit, w_lz_sel, w_oor, w_change, w_boundary, w_drive;

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 7'b1000000;
         4'h1: hex_seg = 7'b1111001;
         4'h2: hex_seg = 7'b0100100;
         4'h3: hex_seg = 7'b0110000;
         4'h4: hex_seg = 7'b0011001;
         4'h5: hex_seg = 7'b0010010;
         4'h6: hex_seg = 7'b0000010;
         4'h7: hex_seg = 7'b1111000;
         4'h8: hex_seg = 7'b0000000;
         4'h9: hex_seg = 7'b0010000;
         4'hA: hex_seg = 7'b0001000;
         4'hB: hex_seg = 7'b0000011;
         4'hC: hex_seg = 7'b1000110;
         4'hD: hex_seg = 7'b0100001;
         4'hE: hex_seg = 7'b0000110;
         default: hex_seg = 7'b0001110;
      endcase
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   logic w_lz_run;
   // Walk down from the top digit; the run of zeros stops at the first non-zero nibble.
   always_comb begin
      w_lz_run  = 1'b1;
      w_lz_mask = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         w_lz_run     = w_lz_run & (w_act_data_nxt[4*i +: 4] == 4'd0);
         w_lz_mask[i] = w_lz_run;
      end
   end
`else
   assign w_lz_mask = '0;
`endif

   always_comb begin
      w_oor      = ({1'b0, digit_sel} >= c_NUM);
      w_change   = (digit_sel != r_prev_sel);
      w_boundary = (r_prev_sel == c_LAST) && (digit_sel == 3'd0);

      w_act_data_nxt = r_act_data;
      w_act_dp_nxt   = r_act_dp;
      if (w_boundary) begin
         w_act_data_nxt = wr_en ? wr_data : r_stage_data;
         w_act_dp_nxt   = wr_en ? wr_dp   : r_stage_dp;
      end

      // Decode from the post-swap buffer so a zero-blank build shows the new frame at digit 0.
      w_nib    = 4'd0;
      w_dp_bit = 1'b0;
      w_lz_sel = 1'b0;
      w_anode  = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_sel == 3'(i)) begin
            w_nib      = w_act_data_nxt[4*i +: 4];
            w_dp_bit   = w_act_dp_nxt[i];
            w_lz_sel   = w_lz_mask[i];
            w_anode[i] = 1'b0;
         end
      end
      w_seg = w_lz_sel ? 7'h7F : hex_seg(w_nib);

      w_drive = !w_oor && (w_change ? (c_BLANK == 4'd0) : (r_blank_cnt <= 4'd1));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_stage_data <= '0;
         r_stage_dp   <= '0;
         r_act_data   <= '0;
         r_act_dp     <= '0;
         r_prev_sel   <= 3'd0;
         r_blank_cnt  <= 4'd0;
         anode_n      <= '1;
         seg_n        <= 7'h7F;
         dp_n         <= 1'b1;
         frame_start  <= 1'b0;
         sel_err      <= 1'b0;
      end else begin
         r_prev_sel  <= digit_sel;
         if (wr_en) begin
            r_stage_data <= wr_data;
            r_stage_dp   <= wr_dp;
         end
         r_act_data  <= w_act_data_nxt;
         r_act_dp    <= w_act_dp_nxt;
         frame_start <= w_boundary;
         sel_err     <= sel_err | w_oor;

         if (w_change)
            r_blank_cnt <= c_BLANK;
         else if (r_blank_cnt != 4'd0)
            r_blank_cnt <= r_blank_cnt - 4'd1;

         if (w_drive) begin
            anode_n <= w_anode;
            seg_n   <= w_seg;
            dp_n    <= ~w_dp_bit;
         end else begin
            anode_n <= '1;
            seg_n   <= 7'h7F;
            dp_n    <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_driver.sv
//------------------------------------------------------------------------------
// tb_digit_scan_driver : directed scan stimulus with queued expectations and a monitor. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_digit_scan_driver;

   localparam int BLANK = 2;
   localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  digit_sel = 3'd0;
   logic        wr_en = 1'b0;
   logic [27:0] wr_data = '0;
   logic [6:0]  wr_dp = '0;
   logic [6:0]  anode_n, seg_n;
   logic        dp_n, frame_start, sel_err;

   digit_scan_driver #(.NUM_DIGITS(7), .BLANK_CYCLES(BLANK)) dut (
      .clock(clock), .reset(reset), .digit_sel(digit_sel), .wr_en(wr_en),
      .wr_data(wr_data), .wr_dp(wr_dp), .anode_n(anode_n), .seg_n(seg_n),
      .dp_n(dp_n), .frame_start(frame_start), .sel_err(sel_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [6:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
      logic       err;
      string      nm;
   } exp_t;

   exp_t q[$];
   event ev_out;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic err_exp  = 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(ev_out);
         n_checks++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: no expectation queued at %0t", $time);
         end else begin
            e = q.pop_front();
            if ({anode_n, seg_n, dp_n, frame_start, sel_err} !== {e.an, e.seg, e.dp, e.fs, e.err}) begin
               n_fail++;
               $display("FAIL %s: got an=%b seg=%b dp=%b fs=%b err=%b, want an=%b seg=%b dp=%b fs=%b err=%b",
                        e.nm, anode_n, seg_n, dp_n, frame_start, sel_err, e.an, e.seg, e.dp, e.fs, e.err);
            end
         end
      end
   end

   task automatic step(input logic [2:0] sel, input logic wen, input logic [27:0] d, input logic [6:0] wdp,
                       input logic [6:0] ean, input logic [6:0] eseg, input logic edp, input logic efs,
                       input string nm);
      exp_t e;
      digit_sel = sel;
      wr_en     = wen;
      wr_data   = d;
      wr_dp     = wdp;
      e.an  = ean;
      e.seg = eseg;
      e.dp  = edp;
      e.fs  = efs;
      e.err = err_exp;
      e.nm  = nm;
      q.push_back(e);
      @(posedge clock);
      #1;
      -> ev_out;
   endtask

   // One digit change: BLANK dark cycles, then one cycle of the new digit.
   task automatic visit(input logic [2:0] sel, input logic fs, input logic wen, input logic [27:0] d,
                        input logic [6:0] wdp, input logic [6:0] eseg, input logic edp, input string nm);
      for (int k = 0; k < BLANK; k++)
         step(sel, (k == 0) ? wen : 1'b0, d, wdp, 7'h7F, 7'h7F, 1'b1, (k == 0) ? fs : 1'b0, {nm, "_blank"});
      step(sel, (BLANK == 0) ? wen : 1'b0, d, wdp, 7'h7F ^ (7'h01 << sel), eseg, edp,
           (BLANK == 0) ? fs : 1'b0, nm);
   endtask

   initial begin
      logic [27:0] f;
      logic [6:0]  fdp;

      reset = 1'b1;
      step(3'd0, 1'b0, '0, '0, 7'h7F, 7'h7F, 1'b1, 1'b0, "reset");
      reset = 1'b0;

      for (int d = 1; d < 7; d++) visit(3'(d), 1'b0, 1'b0, '0, '0, SEG[0], 1'b1, "zero_scan");
      visit(3'd0, 1'b1, 1'b0, '0, '0, SEG[0], 1'b1, "boundary_zero");

      // Staged frame stays invisible until the wrap.
      visit(3'd1, 1'b0, 1'b1, 28'h6543210, 7'b0001000, SEG[0], 1'b1, "stage_hold");
      for (int d = 2; d < 7; d++) visit(3'(d), 1'b0, 1'b0, '0, '0, SEG[0], 1'b1, "stage_hold");
      visit(3'd0, 1'b1, 1'b0, '0, '0, SEG[0], 1'b1, "swap_d0");
      f = 28'h6543210;
      for (int d = 1; d < 7; d++) visit(3'(d), 1'b0, 1'b0, '0, '0, SEG[f[4*d +: 4]], (d == 3) ? 1'b0 : 1'b1, "frame1");

      // Write-through in the boundary cycle; later writes only touch staging.
      f   = 28'hCBAD8EF;
      fdp = 7'b0000100;
      visit(3'd0, 1'b1, 1'b1, f, fdp, SEG[15], 1'b1, "wthru_d0");
      for (int d = 1; d < 7; d++) begin
         if (d == 3)
            visit(3'(d), 1'b0, 1'b1, 28'h1111111, 7'h00, SEG[f[4*d +: 4]], ~fdp[d], "wthru_frame");
         else if (d == 4)
            visit(3'(d), 1'b0, 1'b1, 28'h2222222, 7'b1000000, SEG[f[4*d +: 4]], ~fdp[d], "wthru_frame");
         else
            visit(3'(d), 1'b0, 1'b0, '0, '0, SEG[f[4*d +: 4]], ~fdp[d], "wthru_frame");
      end
      visit(3'd0, 1'b1, 1'b0, '0, '0, SEG[2], 1'b1, "last_write_d0");
      visit(3'd1, 1'b0, 1'b0, '0, '0, SEG[2], 1'b1, "last_write_d1");
      visit(3'd2, 1'b0, 1'b0, '0, '0, SEG[2], 1'b1, "last_write_d2");

      // Out-of-range select.
      err_exp = 1'b1;
      step(3'd7, 1'b0, '0, '0, 7'h7F, 7'h7F, 1'b1, 1'b0, "oor");
      step(3'd7, 1'b0, '0, '0, 7'h7F, 7'h7F, 1'b1, 1'b0, "oor_hold");
      visit(3'd0, 1'b0, 1'b0, '0, '0, SEG[2], 1'b1, "after_oor_no_fs");
      visit(3'd6, 1'b0, 1'b0, '0, '0, SEG[2], 1'b0, "d6_dp");
      visit(3'd0, 1'b1, 1'b0, '0, '0, SEG[2], 1'b1, "boundary_after_oor");

      // Change during blanking restarts the dead time.
      step(3'd3, 1'b0, '0, '0, 7'h7F, 7'h7F, 1'b1, 1'b0, "toggle3");
      step(3'd4, 1'b0, '0, '0, 7'h7F, 7'h7F, 1'b1, 1'b0, "toggle4");
      visit(3'd3, 1'b0, 1'b0, '0, '0, SEG[2], 1'b1, "toggle3_final");

      // Mid-frame reset clears buffers and the sticky error.
      reset   = 1'b1;
      err_exp = 1'b0;
      step(3'd3, 1'b0, '0, '0, 7'h7F, 7'h7F, 1'b1, 1'b0, "mid_reset");
      reset = 1'b0;
      visit(3'd3, 1'b0, 1'b0, '0, '0, SEG[0], 1'b1, "post_reset");
      visit(3'd4, 1'b0, 1'b1, 28'h0000120, '0, SEG[0], 1'b1, "lz_stage");
      visit(3'd5, 1'b0, 1'b0, '0, '0, SEG[0], 1'b1, "lz_stage");
      visit(3'd6, 1'b0, 1'b0, '0, '0, SEG[0], 1'b1, "lz_stage");
      visit(3'd0, 1'b1, 1'b0, '0, '0, SEG[0], 1'b1, "lz_d0");
      visit(3'd1, 1'b0, 1'b0, '0, '0, SEG[2], 1'b1, "lz_d1");
      visit(3'd2, 1'b0, 1'b0, '0, '0, SEG[1], 1'b1, "lz_d2");
      for (int d = 3; d < 7; d++) begin
`ifdef LEADING_ZERO_BLANK_EN
         visit(3'(d), 1'b0, 1'b0, '0, '0, 7'h7F, 1'b1, "lz_upper");
`else
         visit(3'(d), 1'b0, 1'b0, '0, '0, SEG[0], 1'b1, "lz_upper");
`endif
      end

      #2;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d pending, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
